mult_share_arbiter: RTL and testbench
=====================================

// Module: mult_share_arbiter
// PURPOSE
//  Shares one shift-add multiplier datapath (shift register + accumulating counter) between NREQ requesters.
//  Round-robin arbitration; sequences the datapath with the standard control codes: load, N add/shift cycles, result write.
//  Sits between requester ports and the operand mux / shift_reg / counter; the multiplier core has no arbitration of its own.
// PARAMETERS
//  N     8  operand width = add/shift cycles per multiply
//  NREQ  4  number of requesters (2..8); localparam SW = $clog2(NREQ)
// PORTS
//  clock    in   1      single clock; all state changes on the falling edge, so the datapath sees stable controls on rising edges
//  reset    in   1      synchronous, active-high
//  req      in   NREQ   request per requester; held high until done, dropping it aborts
//  y        in   1      analysed bit from the shift register (current multiplier LSB)
//  grant    out  NREQ   one-hot owner of the datapath; 0 when idle
//  sel      out  SW     operand/result mux select = index of the granted requester
//  c_sh_rg  out  2      shift-register control: 0 hold, 2 shift, 3 load
//  c_cnt    out  2      counter control: 0 hold, 2 add, 3 load
//  res_we   out  1      1-cycle write strobe for the result register of requester sel
//  done     out  NREQ   1-cycle completion pulse for the granted requester
//  busy     out  1      datapath owned (CYCLE or DONE)
// BEHAVIOUR
//  - All outputs registered. Reset values: grant=0, sel=0, c_sh_rg=0, c_cnt=0, res_we=0, done=0, busy=0; state=IDLE, k=0, ptr=0.
//  - FSM: IDLE -> CYCLE -> DONE -> IDLE. k is the cycle counter, 0..N; it needs $clog2(N+1) bits.
//  - IDLE with |req: pick winner w = first set req at or after ptr, wrapping modulo NREQ.
//    Set grant=1<<w, sel=w, busy=1, k=0, c_sh_rg=3, c_cnt=3 (load), go to CYCLE. IDLE with req=0: all controls 0.
//  - CYCLE, k<N, req[w]=1: c_sh_rg=2, c_cnt={y,1'b0} (add when y=1, hold when y=0), k=k+1.
//  - CYCLE, k==N, req[w]=1: c_sh_rg=0, c_cnt=0, res_we=1, done[w]=1, go to DONE.
//  - DONE: res_we=0, done=0, grant=0, busy=0, ptr=(w+1) mod NREQ, go to IDLE.
//  - Latency: grant at edge E0; load code active E0..E1; add/shift codes from E1 through E(N+1); res_we/done pulse E(N+1)..E(N+2).
//    Next grant no earlier than E(N+3), so an op occupies N+3 clocks.
//  - Abort: req[w]=0 sampled in CYCLE at any k, including k==N. Go to IDLE with all controls 0, grant=0, busy=0, ptr=w+1; no done, no res_we. Abort wins over completion.
//  - Requests from non-owners are ignored while busy; they are not queued beyond their level.
//  - ptr wraps NREQ-1 -> 0. With a single requester held high it is re-granted every N+3 clocks.
//  - Reset in any state returns to reset values at that edge; an in-flight op is discarded with no done.
//  - y is sampled only in CYCLE with k<N; it is ignored elsewhere.
// CONFIGURATION
//  MULT_ARB_FIXED_PRIO_EN defined: winner = lowest-index set req; ptr is unused and held at 0; starvation is allowed.
//  Undefined (default): round-robin as above.
// TESTING
//  1 reset=1 for 2 clocks during CYCLE -> all outputs 0 next edge; no done; then req[1] proceeds normally.
//  2 req=4'b0010, N=8, y stream 1,0,1,1,0,0,1,0:
//    -> grant=0010, sel=1, c_sh_rg=3/c_cnt=3 for one clock;
//    -> c_cnt sequence 2,0,2,2,0,0,2,0 with c_sh_rg=2;
//    -> done=0010 and res_we=1 one clock; total 11 clocks.
//  3 req=4'b0101 held high -> grants 0001, 0100, 0001, 0100...; each done exactly once per grant.
//  4 req=4'b1111 held high -> grant order 0001, 0010, 0100, 1000, 0001; no requester waits more than 3 ops.
//  5 req[2] dropped at k=4 -> next edge IDLE, grant=0, no done/res_we; req[3] pending is granted next.
//  6 with MULT_ARB_FIXED_PRIO_EN, req=4'b1001 held high -> grant=0001 on every op; req[3] never granted.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one shift-add multiplier datapath among NREQ requesters.
// Define MULT_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module mult_share_arbiter #(
    parameter int unsigned N    = 8,
    parameter int unsigned NREQ = 4,
    localparam int unsigned SW  = $clog2(NREQ)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            y,
    output logic [NREQ-1:0] grant,
    output logic [SW-1:0]   sel,
    output logic [1:0]      c_sh_rg,
    output logic [1:0]      c_cnt,
    output logic            res_we,
    output logic [NREQ-1:0] done,
    output logic            busy
);

    localparam int unsigned KW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CYCLE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [SW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [1:0]      c_sh_rg_q, c_sh_rg_d;
    logic [1:0]      c_cnt_q, c_cnt_d;
    logic            res_we_q, res_we_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            busy_q, busy_d;

    logic            found;
    logic [SW-1:0]   win;
    logic [SW-1:0]   nxt_ptr;
    int unsigned     base;
    int unsigned     idx;

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
`ifdef MULT_ARB_FIXED_PRIO_EN
        base  = 0;
`else
        base  = int'(ptr_q);
`endif
        // Scan from the rotating base so the first hit is the round-robin winner.
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (base + i) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = SW'(idx);
            end
        end
`ifdef MULT_ARB_FIXED_PRIO_EN
        nxt_ptr = '0;
`else
        nxt_ptr = (int'(sel_q) == NREQ - 1) ? '0 : sel_q + SW'(1);
`endif
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        c_sh_rg_d = '0;
        c_cnt_d   = '0;
        res_we_d  = 1'b0;
        done_d    = '0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d   = NREQ'(1) << win;
                    sel_d     = win;
                    busy_d    = 1'b1;
                    k_d       = '0;
                    c_sh_rg_d = 2'd3;
                    c_cnt_d   = 2'd3;
                    state_d   = CYCLE;
                end else begin
                    grant_d = '0;
                    sel_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            CYCLE: begin
                if (!req[sel_q]) begin
                    grant_d = '0;
                    sel_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = nxt_ptr;
                    state_d = IDLE;
                end else if (k_q < KW'(N)) begin
                    c_sh_rg_d = 2'd2;
                    c_cnt_d   = {y, 1'b0};
                    k_d       = k_q + KW'(1);
                end else begin
                    res_we_d = 1'b1;
                    done_d   = grant_q;
                    state_d  = DONE;
                end
            end
            DONE: begin
                grant_d = '0;
                sel_d   = '0;
                busy_d  = 1'b0;
                ptr_d   = nxt_ptr;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                sel_d   = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Falling-edge state so the datapath samples settled controls on the rising edge.
    always_ff @(negedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            k_q       <= '0;
            ptr_q     <= '0;
            grant_q   <= '0;
            sel_q     <= '0;
            c_sh_rg_q <= '0;
            c_cnt_q   <= '0;
            res_we_q  <= 1'b0;
            done_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            c_sh_rg_q <= c_sh_rg_d;
            c_cnt_q   <= c_cnt_d;
            res_we_q  <= res_we_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign c_sh_rg = c_sh_rg_q;
    assign c_cnt   = c_cnt_q;
    assign res_we  = res_we_q;
    assign done    = done_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter: operation-level reference model, random req/y/reset stimulus.
module tb_mult_share_arbiter;

    localparam int unsigned N    = 8;
    localparam int unsigned NREQ = 4;
    localparam int unsigned SW   = $clog2(NREQ);

    logic            clock = 1'b0;
    logic            reset;
    logic [NREQ-1:0] req;
    logic            y;
    logic [NREQ-1:0] grant;
    logic [SW-1:0]   sel;
    logic [1:0]      c_sh_rg;
    logic [1:0]      c_cnt;
    logic            res_we;
    logic [NREQ-1:0] done;
    logic            busy;

    mult_share_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .y       (y),
        .grant   (grant),
        .sel     (sel),
        .c_sh_rg (c_sh_rg),
        .c_cnt   (c_cnt),
        .res_we  (res_we),
        .done    (done),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [NREQ-1:0] grant;
        logic [SW-1:0]   sel;
        logic [1:0]      sh;
        logic [1:0]      cnt;
        logic            we;
        logic [NREQ-1:0] done;
        logic            busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Operation-level model: owner index, clocks elapsed since its grant, next-to-serve pointer.
    int owner = -1;
    int age   = 0;
    int rr    = 0;
    int n_ops = 0;

    function automatic int pick(input logic [NREQ-1:0] r, input int start);
        for (int j = 0; j < NREQ; j++) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
            if (r[j]) return j;
`else
            if (r[(start + j) % NREQ]) return (start + j) % NREQ;
`endif
        end
        return -1;
    endfunction

    task automatic release_owner();
`ifndef MULT_ARB_FIXED_PRIO_EN
        rr = (owner + 1) % NREQ;
`endif
        owner = -1;
    endtask

    always @(negedge clock) begin
        exp_t e;
        e = '0;
        if (reset) begin
            owner = -1;
            rr    = 0;
        end else if (owner < 0) begin
            if (req != '0) begin
                owner = pick(req, rr);
                age   = 0;
                n_ops++;
                e.sh  = 2'd3;
                e.cnt = 2'd3;
            end
        end else begin
            age++;
            if (age <= N + 1 && !req[owner]) begin
                release_owner();
            end else if (age <= N) begin
                e.sh  = 2'd2;
                e.cnt = y ? 2'd2 : 2'd0;
            end else if (age == N + 1) begin
                e.we   = 1'b1;
                e.done = NREQ'(1) << owner;
            end else begin
                release_owner();
            end
        end
        if (owner >= 0) begin
            e.grant = NREQ'(1) << owner;
            e.sel   = SW'(owner);
            e.busy  = 1'b1;
        end
        exp_q.push_back(e);
    end

    always @(posedge clock) begin
        exp_t e;
        exp_t g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = '{grant, sel, c_sh_rg, c_cnt, res_we, done, busy};
            n_cmp++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL outputs @%0t: got grant=%b sel=%0d sh=%0d cnt=%0d we=%b done=%b busy=%b | required grant=%b sel=%0d sh=%0d cnt=%0d we=%b done=%b busy=%b",
                         $time, g.grant, g.sel, g.sh, g.cnt, g.we, g.done, g.busy,
                         e.grant, e.sel, e.sh, e.cnt, e.we, e.done, e.busy);
            end
        end
    end

    task automatic cyc(input logic [NREQ-1:0] r, input logic rst);
        req   = r;
        reset = rst;
        y     = 1'($urandom_range(0, 1));
        @(posedge clock);
        #1;
    endtask

    task automatic hold(input logic [NREQ-1:0] r, input int cycles);
        for (int i = 0; i < cycles; i++) cyc(r, 1'b0);
    endtask

    initial begin
        logic [NREQ-1:0] r;
        req   = '0;
        y     = 1'b0;
        reset = 1'b1;
        hold('0, 0);
        for (int i = 0; i < 3; i++) cyc('0, 1'b1);

        // Single op, then idle, then alternating and all-request patterns.
        hold(4'b0010, 11);
        hold(4'b0000, 3);
        hold(4'b0101, 30);
        hold(4'b1111, 60);
        hold(4'b0000, 2);

        // Reset held 2 clocks mid-op, then requester 1 runs normally.
        hold(4'b0010, 5);
        cyc(4'b0010, 1'b1);
        cyc(4'b0010, 1'b1);
        hold(4'b0010, 14);

        // Abort of requester 2 at k=4 while requester 3 waits.
        hold(4'b0000, 2);
        hold(4'b0100, 1);
        hold(4'b1100, 5);
        hold(4'b1000, 14);
        hold(4'b0000, 2);

        // Single requester at the top index: pointer wrap and back-to-back re-grants.
        hold(4'b1000, 25);
        hold(4'b1001, 40);

        r = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < NREQ; b++)
                if ($urandom_range(0, 29) == 0) r[b] = ~r[b];
            cyc(r, 1'($urandom_range(0, 399) == 0));
        end

        hold('0, 4);
        if (n_ops == 0) begin
            n_fail++;
            $display("FAIL op_count: got %0d granted operations, required at least 1", n_ops);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
